uart_tx64: RTL and testbench

Serialises a 64-bit word into eight 8N1 UART frames, least-significant byte first, and pulses a completion flag after the last stop bit. It is the transmit-side counterpart of the 64-bit UART receive path. A word sent by this block is reassembled bit-exact by that receiver when both are built with the same clock frequency, baud rate and parity setting.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 116 +++++++++++
 rtl/uart_tx64.sv | 73 +++++++
 tb/tb_uart_tx64.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, baud divider derivation and word size.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int BYTES_PER_WORD = 8;
  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_UART_BPS   = 115200;

  // Clocks per bit; integer division, 434 at the default clock and baud.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 frame generator with baud counter; optional even parity via UART_TX_PARITY_EN.
// A start strobe in the final stop-bit clock chains the next frame with no gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       uart_txd,
  output logic       byte_done
);

  localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  uart_state_e      state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [2:0]       bit_inc;
  logic [7:0]       byte_reg;
  logic             txd_nxt;
  logic             load;
  logic             baud_end;

  assign baud_end = (baud_cnt == CNT_LAST);
  assign bit_inc  = bit_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      uart_txd <= txd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load) byte_reg <= byte_in;
  end

  // uart_txd is registered from the next-state decision, so the line changes on the same edge as the state.
  always_comb begin
    state_nxt    = state;
    bit_idx_nxt  = bit_idx;
    txd_nxt      = uart_txd;
    load         = 1'b0;
    byte_done    = 1'b0;
    baud_cnt_nxt = (state == ST_IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        txd_nxt = 1'b1;
        if (start) begin
          state_nxt = ST_START;
          txd_nxt   = 1'b0;
          load      = 1'b1;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = 3'd0;
          txd_nxt     = byte_reg[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
            txd_nxt   = ^byte_reg;
`else
            state_nxt = ST_STOP;
            txd_nxt   = 1'b1;
`endif
          end else begin
            bit_idx_nxt = bit_inc;
            txd_nxt     = byte_reg[bit_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          state_nxt = ST_STOP;
          txd_nxt   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          byte_done = 1'b1;
          if (start) begin
            state_nxt = ST_START;
            txd_nxt   = 1'b0;
            load      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx64.sv
// 64-bit word UART transmitter: eight back-to-back frames, LSB byte first, done pulse after the last stop bit.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame.
module uart_tx64
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int UART_BPS = DEF_UART_BPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  output logic        tx_ready,
  output logic        uart_txd,
  output logic        data_send_done
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  // Byte 0 goes straight from data_in into the frame engine, so only bytes 1..7 are held here.
  logic [55:0] word_sr;
  logic [2:0]  byte_idx;
  logic        accept;
  logic        byte_done;
  logic        next_byte;
  logic        byte_start;
  logic [7:0]  byte_sel;

  assign accept     = tx_ready && data_in_valid;
  assign next_byte  = byte_done && (byte_idx != LAST_BYTE);
  assign byte_start = accept || next_byte;
  assign byte_sel   = accept ? data_in[7:0] : word_sr[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ready       <= 1'b1;
      data_send_done <= 1'b0;
      byte_idx       <= '0;
    end else begin
      data_send_done <= 1'b0;
      if (accept) begin
        tx_ready <= 1'b0;
        byte_idx <= '0;
      end else if (next_byte) begin
        byte_idx <= byte_idx + 3'd1;
      end else if (byte_done) begin
        tx_ready       <= 1'b1;
        data_send_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      word_sr <= data_in[63:8];
    end else if (next_byte) begin
      word_sr <= {8'h00, word_sr[55:8]};
    end
  end

  uart_tx_byte #(
    .BPS_CNT (BPS_CNT)
  ) u_tx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_sel),
    .start     (byte_start),
    .uart_txd  (uart_txd),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_uart_tx64.sv
// Directed bench for uart_tx64: clock-exact frame decoding, ignored requests, mid-word reset, back-to-back words.
`timescale 1ns/1ps
module tb_uart_tx64;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 1_000_000;
  localparam int BPS      = 50;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic [63:0] data_in;
  logic        data_in_valid;
  logic        tx_ready;
  logic        uart_txd;
  logic        data_send_done;

  int n_checks;
  int n_errs;
  int done_seen;

  uart_tx64 #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .tx_ready       (tx_ready),
    .uart_txd       (uart_txd),
    .data_send_done (data_send_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_send_done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_level(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (FRAME_BITS == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  // Entered on the first clock of the start bit; leaves on the first clock after the stop bit.
  task automatic rx_frame(input logic [7:0] exp, input string tag);
    logic [7:0] got;
    int bad;
    got = 8'h00;
    bad = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int k = 0; k < BPS; k++) begin
        if (b >= 1 && b <= 8 && k == BPS / 2) got[b-1] = uart_txd;
        if (uart_txd !== exp_level(exp, b)) bad++;
        @(negedge clk);
      end
    end
    check_eq({tag, "_byte"}, {56'h0, got}, {56'h0, exp});
    check_eq({tag, "_bit_timing_errs"}, 64'(bad), 64'd0);
  endtask

  task automatic rx_word(input logic [63:0] w, input string tag);
    for (int i = 0; i < 8; i++) rx_frame(w[8*i +: 8], $sformatf("%s_b%0d", tag, i));
  endtask

  task automatic send_word(input logic [63:0] w);
    data_in       = w;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errs        = 0;
    done_seen     = 0;
    rst_n         = 1'b0;
    data_in       = 64'h0;
    data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", {63'h0, uart_txd}, 64'd1);
    check_eq("rst_ready", {63'h0, tx_ready}, 64'd1);
    check_eq("rst_done", {63'h0, data_send_done}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word A: first frame 0x5D, last 0x91
    send_word(64'h91EF9BE64104FB5D);
    check_eq("a_start_bit", {63'h0, uart_txd}, 64'd0);
    check_eq("a_ready_low", {63'h0, tx_ready}, 64'd0);
    rx_word(64'h91EF9BE64104FB5D, "a");
    check_eq("a_done", {63'h0, data_send_done}, 64'd1);
    check_eq("a_ready_high", {63'h0, tx_ready}, 64'd1);

    // Word B requested in the done cycle; junk requests during transmission
    send_word(64'h0123456789ABCDEF);
    check_eq("b2b_start_bit", {63'h0, uart_txd}, 64'd0);
    check_eq("b2b_done_clear", {63'h0, data_send_done}, 64'd0);
    fork
      rx_word(64'h0123456789ABCDEF, "b");
      begin
        for (int p = 0; p < 5; p++) begin
          repeat (700) @(negedge clk);
          data_in       = 64'hDEAD_BEEF_0000_0000 | 64'(p);
          data_in_valid = 1'b1;
          @(negedge clk);
          data_in_valid = 1'b0;
        end
      end
    join
    check_eq("b_done", {63'h0, data_send_done}, 64'd1);
    repeat (3) @(negedge clk);
    check_eq("idle_txd", {63'h0, uart_txd}, 64'd1);
    check_eq("done_count_ab", 64'(done_seen), 64'd2);

    // Word C aborted by reset during byte 3
    send_word(64'hFEDCBA9876543210);
    for (int i = 0; i < 3; i++) rx_frame(8'h10 + 8'(i * 8'h22), $sformatf("c_b%0d", i));
    repeat (4 * BPS) @(negedge clk);
    check_eq("c_mid_busy", {63'h0, tx_ready}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_txd", {63'h0, uart_txd}, 64'd1);
    check_eq("abort_ready", {63'h0, tx_ready}, 64'd1);
    check_eq("abort_done", {63'h0, data_send_done}, 64'd0);
    rst_n = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    check_eq("abort_line_idle", {63'h0, uart_txd}, 64'd1);
    check_eq("abort_no_done", 64'(done_seen), 64'd2);

    // Word D after the abort
    send_word(64'hA5C3_00FF_8001_7E3C);
    rx_word(64'hA5C3_00FF_8001_7E3C, "d");
    check_eq("d_done", {63'h0, data_send_done}, 64'd1);
    @(negedge clk);
    check_eq("d_done_pulse_len", {63'h0, data_send_done}, 64'd0);
    @(negedge clk);
    check_eq("done_count_total", 64'(done_seen), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
